// File: rtl/mlp_pkg.sv
// Shared types and helpers for the two-layer perceptron training core:
// FSM state encoding, derived-width functions and the weight saturator.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HID  = 3'd1,
    OUT  = 3'd2,
    ERR  = 3'd3,
    UPD  = 3'd4,
    RESP = 3'd5
  } state_t;

  function automatic int calc_h_w(input int w_w, input int n_in);
    return w_w + $clog2(n_in);
  endfunction

  function automatic int calc_y_w(input int h_w, input int w_w, input int n_hid);
    return h_w + w_w + $clog2(n_hid) + 1;
  endfunction

  function automatic int calc_a_w(input int n_in, input int n_hid);
    return $clog2(n_hid * (n_in + 1));
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mlp_sat_update.sv
// Delta-rule step for one output weight: w + floor((e*h) / 2^LR_SHIFT),
// saturated back into the signed weight range.
module mlp_sat_update
  import mlp_pkg::*;
#(
  parameter int W_W      = 8,
  parameter int H_W      = 10,
  parameter int E_W      = 21,
  parameter int LR_SHIFT = 4
) (
  input  logic signed [E_W-1:0] e,
  input  logic        [H_W-1:0] h,
  input  logic signed [W_W-1:0] w,
  output logic signed [W_W-1:0] w_new
);

  localparam int P_W = E_W + H_W + 1;

  logic signed [P_W-1:0] prod_s;
  logic signed [P_W-1:0] shr_s;
  logic signed [P_W:0]   sum_s;

  // h is a non-negative activation, so it enters the product zero-extended.
  assign prod_s = P_W'(e) * P_W'($signed({1'b0, h}));
  assign shr_s  = prod_s >>> LR_SHIFT;
  assign sum_s  = (P_W + 1)'(shr_s) + (P_W + 1)'(w);
  assign w_new  = W_W'(sat_w(64'(sum_s), W_W));

endmodule

// File: rtl/mlp_train_core.sv
// Two-layer perceptron with runtime-loaded weights, sequential forward pass
// and on-chip delta-rule training of the output layer.
module mlp_train_core
  import mlp_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_HID    = 2,
  parameter int W_W      = 8,
  parameter int T_W      = 8,
  parameter int LR_SHIFT = 4,
  parameter int TOL      = 2,
  parameter int CONV_N   = 4,
  parameter int CNT_W    = 16,
  localparam int H_W     = calc_h_w(W_W, N_IN),
  localparam int Y_W     = calc_y_w(H_W, W_W, N_HID),
  localparam int A_W     = calc_a_w(N_IN, N_HID)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  x_i,
  input  logic [T_W-1:0]   target_i,
  input  logic             train_i,
  input  logic             w_we_i,
  input  logic [A_W-1:0]   w_addr_i,
  input  logic [W_W-1:0]   w_data_i,
  output logic [Y_W-1:0]   y_o,
  output logic [Y_W:0]     err_o,
  output logic             y_valid_o,
  output logic             busy_o,
  output logic             converged_o,
  output logic [CNT_W-1:0] sample_cnt_o
);

  localparam int KW  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int CW  = $clog2(CONV_N + 1);
  localparam int P_W = H_W + W_W + 1;
  localparam logic signed [Y_W:0] TOL_V = (Y_W + 1)'(TOL);

  state_t state_r;
  state_t state_next_s;

  logic [KW-1:0]         k_r;
  logic [N_IN-1:0]       x_r;
  logic [T_W-1:0]        target_r;
  logic                  train_r;
  logic signed [W_W-1:0] w1_r [N_HID][N_IN];
  logic signed [W_W-1:0] w2_r [N_HID];
  logic [H_W-1:0]        h_r [N_HID];
  logic signed [Y_W-1:0] acc_r;
  logic signed [Y_W-1:0] y_r;
  logic signed [Y_W:0]   err_r;
  logic                  y_valid_r;
  logic                  busy_r;
  logic [CW-1:0]         conv_cnt_r;
  logic [CNT_W-1:0]      sample_cnt_r;

  logic                  take_s;
  logic                  last_k_s;
  logic signed [H_W-1:0] hsum_s;
  logic [H_W-1:0]        h_relu_s;
  logic signed [P_W-1:0] prod_s;
  logic signed [Y_W:0]   err_s;
  logic                  in_tol_s;
  logic signed [W_W-1:0] w2_new_s;

  assign in_ready_o = (state_r == IDLE) & ~rst_i;
  assign take_s     = in_valid_i & in_ready_o;
  assign last_k_s   = (k_r == KW'(N_HID - 1));

  // Pre-activation sum of hidden unit k over the active features.
  always_comb begin
    hsum_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (x_r[i]) begin
        hsum_s = hsum_s + H_W'(w1_r[k_r][i]);
      end else begin
        hsum_s = hsum_s;
      end
    end
  end

  assign h_relu_s = hsum_s[H_W-1] ? {H_W{1'b0}} : $unsigned(hsum_s);
  assign prod_s   = P_W'($signed({1'b0, h_r[k_r]})) * P_W'(w2_r[k_r]);
  assign err_s    = (Y_W + 1)'($signed({1'b0, target_r})) - (Y_W + 1)'(acc_r);
  assign in_tol_s = (err_r <= TOL_V) && (err_r >= -TOL_V);

  mlp_sat_update #(
    .W_W      (W_W),
    .H_W      (H_W),
    .E_W      (Y_W + 1),
    .LR_SHIFT (LR_SHIFT)
  ) u_sat (
    .e     (err_r),
    .h     (h_r[k_r]),
    .w     (w2_r[k_r]),
    .w_new (w2_new_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; each multi-cycle phase walks k over all hidden units.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (take_s) state_next_s = HID; else state_next_s = IDLE;
      HID:     if (last_k_s) state_next_s = OUT; else state_next_s = HID;
      OUT:     if (last_k_s) state_next_s = ERR; else state_next_s = OUT;
      ERR:     if (train_r) state_next_s = UPD; else state_next_s = RESP;
      UPD:     if (last_k_s) state_next_s = RESP; else state_next_s = UPD;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: weight file, sample capture, forward pass, update and statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_r          <= '0;
      x_r          <= '0;
      target_r     <= '0;
      train_r      <= 1'b0;
      acc_r        <= '0;
      y_r          <= '0;
      err_r        <= '0;
      y_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      conv_cnt_r   <= '0;
      sample_cnt_r <= '0;
      for (int j = 0; j < N_HID; j++) begin
        w2_r[j] <= '0;
        h_r[j]  <= '0;
        for (int i = 0; i < N_IN; i++) begin
          w1_r[j][i] <= '0;
        end
      end
    end else begin
      y_valid_r <= (state_next_s == RESP);
      busy_r    <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          k_r <= '0;
          // A write in the handshake cycle lands before HID reads the weights.
          if (w_we_i) begin
            for (int j = 0; j < N_HID; j++) begin
              for (int i = 0; i < N_IN; i++) begin
                if (w_addr_i == A_W'(j * N_IN + i)) w1_r[j][i] <= w_data_i;
              end
              if (w_addr_i == A_W'(N_HID * N_IN + j)) w2_r[j] <= w_data_i;
            end
          end
          if (take_s) begin
            x_r      <= x_i;
            target_r <= target_i;
            train_r  <= train_i;
            acc_r    <= '0;
          end
        end
        HID: begin
          h_r[k_r] <= h_relu_s;
          k_r      <= last_k_s ? '0 : k_r + KW'(1);
        end
        OUT: begin
          acc_r <= acc_r + Y_W'(prod_s);
          k_r   <= last_k_s ? '0 : k_r + KW'(1);
        end
        ERR: begin
          y_r   <= acc_r;
          err_r <= err_s;
          k_r   <= '0;
        end
        UPD: begin
          w2_r[k_r] <= w2_new_s;
          k_r       <= last_k_s ? '0 : k_r + KW'(1);
          if (last_k_s) begin
            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            if (!in_tol_s) begin
              conv_cnt_r <= '0;
            end else if (conv_cnt_r < CW'(CONV_N)) begin
              conv_cnt_r <= conv_cnt_r + CW'(1);
            end
          end
        end
        RESP: begin
          k_r <= '0;
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

  assign y_o          = y_r;
  assign err_o        = err_r;
  assign y_valid_o    = y_valid_r;
  assign busy_o       = busy_r;
  assign converged_o  = (conv_cnt_r >= CW'(CONV_N));
  assign sample_cnt_o = sample_cnt_r;

endmodule

// File: tb/tb_mlp_train_core.sv
// Directed bench for mlp_train_core: hand-computed expectations are queued on
// issue and popped when the core reports a result.
module tb_mlp_train_core;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         x;
  logic [7:0]         target;
  logic               train;
  logic               w_we;
  logic [3:0]         w_addr;
  logic [7:0]         w_data;
  logic signed [19:0] y;
  logic signed [20:0] err;
  logic               y_valid;
  logic               busy;
  logic               converged;
  logic [15:0]        sample_cnt;

  typedef struct {
    logic signed [63:0] y;
    logic signed [63:0] e;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  mlp_train_core #(
    .N_IN(4), .N_HID(2), .W_W(8), .T_W(8), .LR_SHIFT(4),
    .TOL(2), .CONV_N(4), .CNT_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .x_i          (x),
    .target_i     (target),
    .train_i      (train),
    .w_we_i       (w_we),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .y_o          (y),
    .err_o        (err),
    .y_valid_o    (y_valid),
    .busy_o       (busy),
    .converged_o  (converged),
    .sample_cnt_o (sample_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic stats(input string tag, input int cv, input int cnt);
    chk({tag, "_conv"}, converged, cv);
    chk({tag, "_cnt"}, sample_cnt, cnt);
  endtask

  // mode 0: plain, 1: hold valid with changing x, 2: weight write during OUT,
  // 3: reset in the first UPD cycle
  task automatic run(input string tag, input logic [3:0] xv, input logic [7:0] tv,
                     input logic trv, input int ey, input int ee, input int mode);
    exp_t ex;
    int cyc;
    ex.y = ey; ex.e = ee; ex.lat = trv ? 8 : 6;
    sb.push_back(ex);
    @(negedge clk);
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; x = xv; target = tv; train = trv;
    @(negedge clk);
    cyc = 1;
    x = ~xv; target = ~tv;
    if (mode != 1) in_valid = 1'b0;
    while (!y_valid && cyc < 40) begin
      if (mode == 1) begin
        chk({tag, "_ready_busy"}, in_ready, 0);
        x = 4'($urandom);
      end
      if (mode == 2 && cyc == 3) begin
        w_we = 1'b1; w_addr = 4'd8; w_data = 8'd99;
      end else begin
        w_we = 1'b0;
      end
      if (mode == 3 && cyc == 6) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_y"}, y, 0);
        chk({tag, "_rst_err"}, err, 0);
        chk({tag, "_rst_vld"}, y_valid, 0);
        chk({tag, "_rst_ready"}, in_ready, 0);
        stats({tag, "_rst"}, 0, 0);
        rst = 1'b0;
        ex = sb.pop_front();
        return;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    ex = sb.pop_front();
    chk({tag, "_lat"}, cyc, ex.lat);
    chk({tag, "_y"}, y, ex.y);
    chk({tag, "_err"}, err, ex.e);
    @(negedge clk);
    chk({tag, "_pulse"}, y_valid, 0);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = 4'd0; target = 8'd0; train = 1'b0;
    w_we = 1'b0; w_addr = 4'd0; w_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", y_valid, 0);
    chk("rst_busy", busy, 0);
    stats("rst", 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // w1[0][*]=10, w1[1][*]=0, w2={3,5}
    for (int i = 0; i < 4; i++) wr(4'(i), 8'd10);
    for (int i = 4; i < 8; i++) wr(4'(i), 8'd0);
    wr(4'd8, 8'd3);
    wr(4'd9, 8'd5);
    run("inf1", 4'b0011, 8'd70, 1'b0, 60, 10, 0);
    run("inf2", 4'b1100, 8'd0, 1'b0, 60, -60, 0);

    // ReLU clamps the negative hidden unit, so w2[1] drops out.
    for (int i = 4; i < 8; i++) wr(4'(i), 8'hEC);
    run("relu1", 4'b1111, 8'd0, 1'b0, 120, -120, 0);
    wr(4'd9, 8'd77);
    run("relu2", 4'b1111, 8'd200, 1'b0, 120, 80, 0);
    for (int i = 4; i < 8; i++) wr(4'(i), 8'(i - 3));
    wr(4'd10, 8'd50);
    run("both", 4'b0101, 8'd255, 1'b0, 368, -113, 0);
    for (int i = 4; i < 8; i++) wr(4'(i), 8'd0);
    wr(4'd9, 8'd5);

    // Training: 3 + 800/16 = 53, then saturation to -128.
    run("trn1", 4'b0011, 8'd100, 1'b1, 60, 40, 0);
    stats("trn1", 0, 1);
    run("inf3", 4'b0011, 8'd0, 1'b0, 1060, -1060, 0);
    run("trn2", 4'b0011, 8'd100, 1'b1, 1060, -960, 0);
    run("inf4", 4'b0011, 8'd0, 1'b0, -2560, 2560, 0);
    // Flooring shift: 3 + floor(-100/16) = -4.
    wr(4'd8, 8'd3);
    run("trn3", 4'b0011, 8'd55, 1'b1, 60, -5, 0);
    run("inf5", 4'b0011, 8'd0, 1'b0, -80, 80, 0);
    // Both units train: w2 = {3+18, 5+4}.
    wr(4'd8, 8'd3);
    wr(4'd4, 8'd5);
    run("trn4", 4'b0011, 8'd100, 1'b1, 85, 15, 0);
    run("inf6", 4'b0011, 8'd0, 1'b0, 465, -465, 0);
    stats("trn4", 0, 4);

    // Convergence with errors 0, +2, -2, 0 (w2[0]: 3, 5, 2, 2).
    wr(4'd4, 8'd0);
    wr(4'd8, 8'd3);
    run("cv1", 4'b0011, 8'd60, 1'b1, 60, 0, 0);
    run("cv2", 4'b0011, 8'd62, 1'b1, 60, 2, 0);
    run("cv3", 4'b0011, 8'd98, 1'b1, 100, -2, 0);
    stats("cv3", 0, 7);
    run("cv4", 4'b0011, 8'd40, 1'b1, 40, 0, 0);
    stats("cv4", 1, 8);
    run("cv_inf", 4'b0011, 8'd0, 1'b0, 40, -40, 0);
    stats("cv_inf", 1, 8);
    run("cv_out", 4'b0011, 8'd43, 1'b1, 40, 3, 0);
    stats("cv_out", 0, 9);

    // Busy protections (w2[0] = 5).
    run("hold", 4'b0011, 8'd0, 1'b0, 100, -100, 1);
    run("wr_out", 4'b0011, 8'd0, 1'b0, 100, -100, 2);
    run("wr_chk", 4'b0011, 8'd0, 1'b0, 100, -100, 0);

    // Reset during UPD clears everything.
    run("rst_upd", 4'b0011, 8'd0, 1'b1, 0, 0, 3);
    run("post_rst", 4'b0011, 8'd33, 1'b0, 0, 33, 0);
    stats("post_rst", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
